uart_bus_master: RTL and testbench
==================================

UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 SHALL provide parameter CLOCK_FREQ, default 62500000, meaning clk frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 115200, meaning serial bit rate.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 6250000, meaning inter-byte timeout in clk cycles.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rx  input  1  serial in, idle high, 8N1, LSB first.
REQ-007 SHALL have port tx  output  1  serial out, idle high, 8N1, LSB first.
REQ-008 SHALL have port a  output  32  bus address.
REQ-009 SHALL have port d  output  32  bus write data.
REQ-010 SHALL have port we  output  1  write qualifier, valid while req high.
REQ-011 SHALL have port req  output  1  bus request strobe.
REQ-012 SHALL have port ready  input  1  bus completion, one-cycle pulse.
REQ-013 SHALL have port spo  input  32  bus read data, valid when ready high.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL build rx sampling from a 16x tick with period CLOCK_FREQ/(BAUD*16) clk cycles, and tx timing from a tick with period CLOCK_FREQ/BAUD, using integer division.
REQ-016 SHALL treat rx low as a start bit only if it is still low at oversample 8; a high there aborts the byte silently.
REQ-017 SHALL sample each data bit at oversample 8 and the stop bit likewise; a low stop bit is a framing error, and the byte is discarded.
REQ-018 SHALL run packet FSM states IDLE -> ADDR -> [DATA] -> BUS -> RESP -> IDLE.
REQ-019 IDLE: byte 0x57 ('W') or 0x52 ('R') SHALL latch cmd, clear byte count and go to ADDR; any other byte SHALL go to RESP sending 0x15.
REQ-020 ADDR SHALL shift in 4 bytes MSB first into a; after the 4th, 'W' SHALL go to DATA and 'R' SHALL go to BUS.
REQ-021 DATA SHALL shift in 4 bytes MSB first into d, then go to BUS.
REQ-022 BUS SHALL assert req with we=1 for 'W' and we=0 for 'R', holding a, d and we stable until the cycle ready=1. That cycle SHALL capture spo, and the next cycle SHALL drop req and enter RESP; bus latency is unbounded.
REQ-023 RESP SHALL transmit 0x06 for 'W', or spo bytes MSB first (4 bytes) for 'R', then return to IDLE.
REQ-024 The first start bit SHALL begin within one tx tick of RESP entry, and bytes SHALL follow back to back with no idle bit.
REQ-025 SHALL ignore ready while req is low.
REQ-026 Bytes completing while in BUS or RESP SHALL be dropped, with no buffering.
REQ-027 A framing error in ADDR or DATA SHALL abort to IDLE with no bus access and no response.
REQ-028 SHALL hold tx high at all times outside RESP transmission.

Reset
REQ-029 On rst, all of the following SHALL apply immediately regardless of clk: tx=1, req=0, we=0, a=0, d=0, busy=0, FSM=IDLE, and receiver, transmitter and divider counters at 0.
REQ-030 Reset mid-byte or mid-transaction SHALL abandon it with no resumption; req SHALL fall in the same instant.

Configuration
REQ-031 With macro UART_BUS_MASTER_TIMEOUT_EN defined, a counter SHALL reload on every accepted byte; reaching TIMEOUT_CYCLES while in ADDR or DATA SHALL return to IDLE with no response and no bus access.
REQ-032 Without UART_BUS_MASTER_TIMEOUT_EN, no timeout logic SHALL exist and a partial packet SHALL wait indefinitely.

Verification
REQ-033 Scenario: rx sends 57 00 00 10 00 DE AD BE EF; ready is pulsed 3 cycles after req -> one req with a=0x00001000, d=0xDEADBEEF, we=1, then tx sends 06.
REQ-034 Scenario: rx sends 52 00 00 00 04; ready pulses with spo=0x12345678 -> we=0 and a=0x00000004, then tx sends 12 34 56 78.
REQ-035 Scenario: rx sends 41 -> no req, tx sends 15, busy returns to 0 after the stop bit.
REQ-036 Scenario: rx sends 57 00 with a stop bit forced low on the 2nd byte, then 52 00 00 00 00 -> the first packet is discarded, and the read completes normally.
REQ-037 Scenario: rst is asserted while req is high during a write -> req=0 and tx=1 asynchronously, and no 06 is ever sent.
REQ-038 Scenario (with UART_BUS_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=1000): rx sends 52 00 then idles 1000 cycles -> busy=0 and no req; a following full 'R' packet is serviced.

Source files
------------

// File: rtl/uart_bus_master.sv
// uart_bus_master: UART-driven 32-bit bus master.
//
// Packets arrive on rx (8N1, LSB first):
//   'W' a3 a2 a1 a0 d3 d2 d1 d0  -> bus write, reply 0x06
//   'R' a3 a2 a1 a0              -> bus read, reply spo bytes MSB first
//   any other first byte         -> reply 0x15
// A framing error inside a packet abandons it silently.
//
// Ports:
//   clk   - sole clock, rising edge
//   rst   - asynchronous active-high reset
//   rx    - serial input, idle high
//   tx    - serial output, idle high
//   a     - bus address
//   d     - bus write data
//   we    - write qualifier, valid while req is high
//   req   - bus request, held until the cycle ready is seen
//   ready - bus completion pulse (ignored while req is low)
//   spo   - bus read data, captured when ready is high
//   busy  - high whenever the packet FSM is not idle
//
// Optional feature: define UART_BUS_MASTER_TIMEOUT_EN to abandon a partial
// packet after TIMEOUT_CYCLES clk cycles without a new byte.
module uart_bus_master #(
    parameter int unsigned CLOCK_FREQ     = 62500000,
    parameter int unsigned BAUD           = 115200,
    parameter int unsigned TIMEOUT_CYCLES = 6250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        tx,
    output logic [31:0] a,
    output logic [31:0] d,
    output logic        we,
    output logic        req,
    input  logic        ready,
    input  logic [31:0] spo,
    output logic        busy
);

    localparam int unsigned OS_DIV  = CLOCK_FREQ / (BAUD * 16);
    localparam int unsigned BIT_DIV = CLOCK_FREQ / BAUD;
    localparam logic [31:0] OS_LAST  = 32'(OS_DIV - 1);
    localparam logic [31:0] BIT_LAST = 32'(BIT_DIV - 1);

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;
    typedef enum logic [2:0] {StIdle, StAddr, StData, StBus, StResp} state_e;

    // ---------------------------------------------------------------- dividers
    logic [31:0] r_os_div;
    logic [31:0] r_bit_div;
    logic        w_os_tick;
    logic        w_bit_tick;

    assign w_os_tick  = (r_os_div == OS_LAST);
    assign w_bit_tick = (r_bit_div == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_os_div  <= '0;
            r_bit_div <= '0;
        end else begin
            r_os_div  <= w_os_tick  ? '0 : r_os_div + 32'd1;
            r_bit_div <= w_bit_tick ? '0 : r_bit_div + 32'd1;
        end
    end

    // ---------------------------------------------------------------- receiver
    logic      r_rx_meta;
    logic      r_rx_sync;
    rx_state_e r_rx_state;
    rx_state_e w_rx_state_d;
    logic [3:0] r_rx_os;
    logic [3:0] w_rx_os_d;
    logic [2:0] r_rx_bit;
    logic [2:0] w_rx_bit_d;
    logic [7:0] r_rx_shift;
    logic [7:0] w_rx_shift_d;
    logic       w_rx_valid;
    logic       w_rx_ferr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_state <= RxIdle;
            r_rx_os    <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_meta  <= rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_state <= w_rx_state_d;
            r_rx_os    <= w_rx_os_d;
            r_rx_bit   <= w_rx_bit_d;
            r_rx_shift <= w_rx_shift_d;
        end
    end

    always_comb begin
        w_rx_state_d = r_rx_state;
        w_rx_os_d    = r_rx_os;
        w_rx_bit_d   = r_rx_bit;
        w_rx_shift_d = r_rx_shift;
        w_rx_valid   = 1'b0;
        w_rx_ferr    = 1'b0;
        if (w_os_tick) begin
            case (r_rx_state)
                RxIdle: begin
                    if (!r_rx_sync) begin
                        w_rx_state_d = RxStart;
                        w_rx_os_d    = '0;
                    end
                end
                RxStart: begin
                    // Confirm the start bit at its midpoint; a glitch aborts quietly.
                    if (r_rx_os == 4'd7) begin
                        w_rx_os_d    = '0;
                        w_rx_bit_d   = '0;
                        w_rx_state_d = r_rx_sync ? RxIdle : RxData;
                    end else begin
                        w_rx_os_d = r_rx_os + 4'd1;
                    end
                end
                RxData: begin
                    if (r_rx_os == 4'd15) begin
                        w_rx_os_d    = '0;
                        w_rx_shift_d = {r_rx_sync, r_rx_shift[7:1]};
                        w_rx_bit_d   = r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) begin
                            w_rx_state_d = RxStop;
                        end
                    end else begin
                        w_rx_os_d = r_rx_os + 4'd1;
                    end
                end
                RxStop: begin
                    if (r_rx_os == 4'd15) begin
                        w_rx_os_d = '0;
                        if (r_rx_sync) begin
                            w_rx_valid   = 1'b1;
                            w_rx_state_d = RxIdle;
                        end else begin
                            w_rx_ferr    = 1'b1;
                            w_rx_state_d = RxWait;
                        end
                    end else begin
                        w_rx_os_d = r_rx_os + 4'd1;
                    end
                end
                RxWait: begin
                    // After a low stop bit, rearm only once the line returns high,
                    // so a held-low line is not mistaken for a new start bit.
                    if (r_rx_sync) begin
                        w_rx_state_d = RxIdle;
                    end
                end
                default: w_rx_state_d = RxIdle;
            endcase
        end
    end

    // ------------------------------------------------------------- transmitter
    logic       r_tx;
    logic [8:0] r_tx_shift;
    logic [3:0] r_tx_cnt;   // bit periods left in the current frame, incl. the one on the line
    logic       w_tx_free;
    logic       w_tx_load;
    logic [7:0] w_tx_byte;

    // The line is free on the tick that ends the stop bit (or when idle), which
    // lets the next start bit follow with no idle gap.
    assign w_tx_free = w_bit_tick && (r_tx_cnt <= 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx       <= 1'b1;
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
        end else if (w_bit_tick) begin
            if (w_tx_load) begin
                r_tx       <= 1'b0;
                r_tx_shift <= {1'b1, w_tx_byte};
                r_tx_cnt   <= 4'd10;
            end else if (r_tx_cnt > 4'd1) begin
                r_tx       <= r_tx_shift[0];
                r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                r_tx_cnt   <= r_tx_cnt - 4'd1;
            end else begin
                r_tx_cnt <= '0;
            end
        end
    end

    // ---------------------------------------------------------- packet FSM
    state_e      r_state;
    state_e      w_state_d;
    logic        r_is_wr;
    logic        w_is_wr_d;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_d;
    logic [31:0] r_a;
    logic [31:0] w_a_d;
    logic [31:0] r_d;
    logic [31:0] w_d_d;
    logic [31:0] r_resp;
    logic [31:0] w_resp_d;
    logic [2:0]  r_left;
    logic [2:0]  w_left_d;
    logic        w_timeout;

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_to_cnt;
    logic        w_in_pkt;

    assign w_in_pkt  = (r_state == StAddr) || (r_state == StData);
    assign w_timeout = w_in_pkt && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_rx_valid || !w_in_pkt) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_LAST) begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_is_wr <= 1'b0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_d     <= '0;
            r_resp  <= '0;
            r_left  <= '0;
        end else begin
            r_state <= w_state_d;
            r_is_wr <= w_is_wr_d;
            r_cnt   <= w_cnt_d;
            r_a     <= w_a_d;
            r_d     <= w_d_d;
            r_resp  <= w_resp_d;
            r_left  <= w_left_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_is_wr_d = r_is_wr;
        w_cnt_d   = r_cnt;
        w_a_d     = r_a;
        w_d_d     = r_d;
        w_resp_d  = r_resp;
        w_left_d  = r_left;
        w_tx_load = 1'b0;
        w_tx_byte = r_resp[31:24];
        case (r_state)
            StIdle: begin
                if (w_rx_valid) begin
                    if (r_rx_shift == 8'h57 || r_rx_shift == 8'h52) begin
                        w_is_wr_d = (r_rx_shift == 8'h57);
                        w_cnt_d   = '0;
                        w_state_d = StAddr;
                    end else begin
                        w_resp_d  = {8'h15, 24'h0};
                        w_left_d  = 3'd1;
                        w_state_d = StResp;
                    end
                end
            end
            StAddr: begin
                if (w_rx_ferr || w_timeout) begin
                    w_state_d = StIdle;
                end else if (w_rx_valid) begin
                    w_a_d   = {r_a[23:0], r_rx_shift};
                    w_cnt_d = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_d = r_is_wr ? StData : StBus;
                    end
                end
            end
            StData: begin
                if (w_rx_ferr || w_timeout) begin
                    w_state_d = StIdle;
                end else if (w_rx_valid) begin
                    w_d_d   = {r_d[23:0], r_rx_shift};
                    w_cnt_d = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_d = StBus;
                    end
                end
            end
            StBus: begin
                if (ready) begin
                    w_resp_d  = r_is_wr ? {8'h06, 24'h0} : spo;
                    w_left_d  = r_is_wr ? 3'd1 : 3'd4;
                    w_state_d = StResp;
                end
            end
            StResp: begin
                if (w_tx_free) begin
                    if (r_left != 3'd0) begin
                        w_tx_load = 1'b1;
                        w_resp_d  = {r_resp[23:0], 8'h00};
                        w_left_d  = r_left - 3'd1;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign tx   = r_tx;
    assign a    = r_a;
    assign d    = r_d;
    assign req  = (r_state == StBus);
    assign we   = (r_state == StBus) && r_is_wr;
    assign busy = (r_state != StIdle);

endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: self-checking bench for uart_bus_master.
// Runs at 32 clk cycles per bit (16x oversample period of 2 cycles) and a
// 1000-cycle timeout. Expected bus accesses and reply bytes are queued as
// stimulus is driven; monitors pop and compare as the DUT produces them.
// Define UART_BUS_MASTER_TIMEOUT_EN for both bench and RTL to exercise the timeout.
module tb_uart_bus_master;

    localparam int unsigned CF  = 3200000;
    localparam int unsigned BR  = 100000;
    localparam int          BIT = 32;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx = 1'b1;
    logic        ready = 1'b0;
    logic [31:0] spo = 32'h0;
    logic        tx;
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic        req;
    logic        busy;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    bus_t   exp_bus[$];
    logic [7:0] exp_tx[$];
    longint tx_starts[$];

    uart_bus_master #(
        .CLOCK_FREQ     (CF),
        .BAUD           (BR),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .tx    (tx),
        .a     (a),
        .d     (d),
        .we    (we),
        .req   (req),
        .ready (ready),
        .spo   (spo),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reply byte monitor: decodes tx at mid-bit and checks against exp_tx.
    always begin : tx_mon
        logic [7:0] got;
        logic [7:0] want;
        logic       stop_b;
        @(negedge clk);
        if (!rst && tx === 1'b0) begin
            tx_starts.push_back(cyc);
            repeat (BIT / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                got[i] = tx;
            end
            repeat (BIT) @(negedge clk);
            stop_b = tx;
            checks++;
            if (exp_tx.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected_byte got %02h required none", got);
            end else begin
                want = exp_tx.pop_front();
                if (got !== want || stop_b !== 1'b1) begin
                    errors++;
                    $display("FAIL tx_byte got %02h stop %b required %02h stop 1",
                             got, stop_b, want);
                end
            end
        end
    end

    // Bus monitor: checks each request against exp_bus and that it holds stable.
    logic        req_q = 1'b0;
    logic        hold_err = 1'b0;
    logic [31:0] hold_a;
    logic [31:0] hold_d;
    logic        hold_we;
    always @(negedge clk) begin
        bus_t e;
        if (req === 1'b1 && !req_q) begin
            hold_a = a; hold_d = d; hold_we = we; hold_err = 1'b0;
            checks++;
            if (exp_bus.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected_req got a=%08h we=%b required none", a, we);
            end else begin
                e = exp_bus.pop_front();
                if (a !== e.a || we !== e.we || (e.we && d !== e.d)) begin
                    errors++;
                    $display("FAIL bus_access got a=%08h d=%08h we=%b required a=%08h d=%08h we=%b",
                             a, d, we, e.a, e.d, e.we);
                end
            end
        end else if (req === 1'b1 && req_q) begin
            if (a !== hold_a || d !== hold_d || we !== hold_we) hold_err = 1'b1;
        end else if (req !== 1'b1 && req_q) begin
            checks++;
            if (hold_err) begin
                errors++;
                $display("FAIL bus_hold got changed required a/d/we stable %08h %08h %b",
                         hold_a, hold_d, hold_we);
            end
        end
        req_q = (req === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish required finish before 2ms");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = ~bad_stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_pkt(input bq_t p);
        foreach (p[i]) send_byte(p[i], 1'b0);
    endtask

    // Waits for req, then pulses ready after lat cycles with spo=val.
    task automatic respond(input int lat, input logic [31:0] val, output longint t_ready);
        int w = 0;
        t_ready = 0;
        while (req !== 1'b1 && w < 6000) begin
            @(negedge clk);
            w++;
        end
        if (req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL bus_req_wait got req=0 required req=1 within 6000 cycles");
        end else begin
            repeat (lat) @(negedge clk);
            spo = val;
            ready = 1'b1;
            t_ready = cyc;
            @(negedge clk);
            ready = 1'b0;
            spo = $urandom;
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while (busy !== 1'b0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        repeat (BIT) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || req !== 1'b0 || we !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_ctrl got tx=%b req=%b we=%b required 1 0 0", tx, req, we);
        end
        checks++;
        if (a !== 32'h0 || d !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_data got a=%08h d=%08h busy=%b required 0 0 0", a, d, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || req !== 1'b0 || busy !== 1'b0 || a !== 32'h0) begin
            errors++;
            $display("FAIL reset_held got tx=%b req=%b busy=%b a=%08h required 1 0 0 0",
                     tx, req, busy, a);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        bq_t p;
        longint t;
        p = {8'h57, 8'h00, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        exp_bus.push_back('{a: 32'h0000_1000, d: 32'hDEAD_BEEF, we: 1'b1});
        exp_tx.push_back(8'h06);
        fork
            send_pkt(p);
            respond(3, 32'h0, t);
        join
        wait_idle();
        checks++;
        if (busy !== 1'b0 || exp_tx.size() != 0 || exp_bus.size() != 0) begin
            errors++;
            $display("FAIL write_done got busy=%b tx_left=%0d bus_left=%0d required 0 0 0",
                     busy, exp_tx.size(), exp_bus.size());
        end
    endtask

    task automatic test_read();
        bq_t p;
        longint t;
        p = {8'h52, 8'h00, 8'h00, 8'h00, 8'h04};
        tx_starts.delete();
        exp_bus.push_back('{a: 32'h0000_0004, d: 32'h0, we: 1'b0});
        exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h56); exp_tx.push_back(8'h78);
        fork
            send_pkt(p);
            respond(5, 32'h1234_5678, t);
        join
        wait_idle();
        checks++;
        if (busy !== 1'b0 || exp_tx.size() != 0 || exp_bus.size() != 0) begin
            errors++;
            $display("FAIL read_done got busy=%b tx_left=%0d bus_left=%0d required 0 0 0",
                     busy, exp_tx.size(), exp_bus.size());
        end
        checks++;
        if (tx_starts.size() != 4 || tx_starts[3] - tx_starts[0] != 3 * 10 * BIT) begin
            errors++;
            $display("FAIL read_back_to_back got starts=%0d span=%0d required 4 %0d",
                     tx_starts.size(), (tx_starts.size() == 4) ? tx_starts[3] - tx_starts[0] : 0,
                     3 * 10 * BIT);
        end
        checks++;
        if (tx_starts.size() == 0 || tx_starts[0] - t < 1 || tx_starts[0] - t > BIT + 2) begin
            errors++;
            $display("FAIL read_first_start got delay=%0d required 1..%0d",
                     (tx_starts.size() != 0) ? tx_starts[0] - t : -1, BIT + 2);
        end
    endtask

    task automatic test_nak();
        exp_tx.push_back(8'h15);
        send_byte(8'h41, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL nak_busy got busy=%b required 1", busy);
        end
        wait_idle();
        checks++;
        if (busy !== 1'b0 || exp_tx.size() != 0) begin
            errors++;
            $display("FAIL nak_done got busy=%b tx_left=%0d required 0 0", busy, exp_tx.size());
        end
    endtask

    task automatic test_ready_ignored();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            spo = 32'hFFFF_FFFF;
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
        end
        repeat (2 * 10 * BIT) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL ready_ignored got busy=%b req=%b tx=%b required 0 0 1", busy, req, tx);
        end
    endtask

    task automatic test_framing();
        bq_t p;
        longint t;
        send_byte(8'h57, 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (2 * BIT) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL framing_abort got busy=%b required 0", busy);
        end
        p = {8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_bus.push_back('{a: 32'h0, d: 32'h0, we: 1'b0});
        exp_tx.push_back(8'hCA); exp_tx.push_back(8'hFE);
        exp_tx.push_back(8'hF0); exp_tx.push_back(8'h0D);
        fork
            send_pkt(p);
            respond(2, 32'hCAFE_F00D, t);
        join
        wait_idle();
        checks++;
        if (busy !== 1'b0 || exp_tx.size() != 0 || exp_bus.size() != 0) begin
            errors++;
            $display("FAIL framing_recover got busy=%b tx_left=%0d bus_left=%0d required 0 0 0",
                     busy, exp_tx.size(), exp_bus.size());
        end
    endtask

    // A byte arriving while the bus access is pending must be dropped.
    task automatic test_drop_in_bus();
        bq_t p;
        longint t;
        p = {8'h52, 8'h00, 8'h00, 8'h00, 8'h08, 8'h41};
        exp_bus.push_back('{a: 32'h0000_0008, d: 32'h0, we: 1'b0});
        exp_tx.push_back(8'h01); exp_tx.push_back(8'h02);
        exp_tx.push_back(8'h03); exp_tx.push_back(8'h04);
        fork
            send_pkt(p);
            respond(500, 32'h0102_0304, t);
        join
        wait_idle();
        repeat (12 * BIT) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || exp_tx.size() != 0) begin
            errors++;
            $display("FAIL drop_in_bus got busy=%b tx_left=%0d required 0 0", busy, exp_tx.size());
        end
    endtask

    task automatic test_timeout();
        bq_t p;
        longint t;
        send_byte(8'h52, 1'b0);
        send_byte(8'h00, 1'b0);
        repeat (1100) @(negedge clk);
`ifdef UART_BUS_MASTER_TIMEOUT_EN
        checks++;
        if (busy !== 1'b0 || req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle got busy=%b req=%b required 0 0", busy, req);
        end
        p = {8'h52, 8'h00, 8'h00, 8'h00, 8'h10};
        exp_bus.push_back('{a: 32'h0000_0010, d: 32'h0, we: 1'b0});
        exp_tx.push_back(8'hA5); exp_tx.push_back(8'hA5);
        exp_tx.push_back(8'h5A); exp_tx.push_back(8'h5A);
        fork
            send_pkt(p);
            respond(1, 32'hA5A5_5A5A, t);
        join
        wait_idle();
        checks++;
        if (busy !== 1'b0 || exp_tx.size() != 0 || exp_bus.size() != 0) begin
            errors++;
            $display("FAIL timeout_recover got busy=%b tx_left=%0d bus_left=%0d required 0 0 0",
                     busy, exp_tx.size(), exp_bus.size());
        end
`else
        p = {};
        t = 0;
        checks++;
        if (busy !== 1'b1 || req !== 1'b0) begin
            errors++;
            $display("FAIL partial_waits got busy=%b req=%b required 1 0", busy, req);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid();
        bq_t p;
        p = {8'h57, 8'h00, 8'h00, 8'h20, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        tx_starts.delete();
        exp_bus.push_back('{a: 32'h0000_2000, d: 32'h1122_3344, we: 1'b1});
        send_pkt(p);
        repeat (4) @(negedge clk);
        checks++;
        if (req !== 1'b1 || we !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_req got req=%b we=%b required 1 1", req, we);
        end
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (req !== 1'b0 || tx !== 1'b1 || we !== 1'b0 || busy !== 1'b0 || a !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_async got req=%b tx=%b we=%b busy=%b a=%08h required 0 1 0 0 0",
                     req, tx, we, busy, a);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // A late ready must not revive the abandoned write.
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (25 * BIT) @(negedge clk);
        checks++;
        if (tx_starts.size() != 0 || busy !== 1'b0 || exp_bus.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_no_ack got tx_bytes=%0d busy=%b bus_left=%0d required 0 0 0",
                     tx_starts.size(), busy, exp_bus.size());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nak();
        test_ready_ignored();
        test_framing();
        test_drop_in_bus();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
